// File: rtl/async_load.sv
// async_load: WIDTH-bit loadable up-counter with a transparent parallel load.
//
// While load is high, out follows in combinationally, with no clock latency.
// The count register captures in on every rising edge while load is high.
// Otherwise the register counts up by one per clock and wraps from all ones to 0.
// A synchronous reset clears the register and forces out to zero at once.
//
// Ports:
//   clk   rising-edge clock, sole clock domain
//   rst   synchronous reset, active-high (the output mux also reacts to it at once)
//   load  parallel load request, active-high, level-sensitive
//   in    parallel load value
//   out   in while loading, otherwise the count register; zero while rst is high
//   co    terminal-count flag, high when out is all ones
module async_load #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             co
);

  logic [WIDTH-1:0] cnt;

  // Priority on each edge: reset, then load, then count.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // the values present before the edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= in;
    else           cnt <= cnt + WIDTH'(1);
  end

  // The output mux has the same priority as the register. This makes reset
  // and load visible straight away, without waiting for an edge.
  // NOTE: out is assigned a default first, so no path through the block can
  // leave it unassigned and infer a latch.
  always_comb begin
    out = cnt;
    if (rst)       out = '0;
    else if (load) out = in;
  end

  // co is taken after the mux, so it also asserts while loading an all-ones value.
  assign co = &out;

endmodule

// File: tb/tb_async_load.sv
// tb_async_load: self-checking bench for async_load (WIDTH = 4).
//
// A directed phase pins hand-computed values for reset, transparent load,
// wrap/carry, live tracking, reset priority and a short load pulse. A random
// phase then drives the inputs both right after the edge and mid-cycle. A
// compare process checks out/co against a behavioural model several times
// per cycle.
module tb_async_load;

  localparam int WIDTH = 4;
  localparam int MODV  = 1 << WIDTH;
  localparam int ALL1  = MODV - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             co;

  int checks = 0;
  int errors = 0;
  bit rand_on = 1'b0;

  // Model of the stored count: a plain integer kept modulo 2^WIDTH.
  int model_cnt = 0;

  async_load #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .in   (in),
    .out  (out),
    .co   (co)
  );

  always #5 clk = ~clk;

  // Update the model on each edge from the edge-priority rules.
  always @(posedge clk) begin
    if (rst)       model_cnt = 0;
    else if (load) model_cnt = int'(in);
    else           model_cnt = (model_cnt + 1) % MODV;
  end

  // The value out should show right now, from the live inputs and the model.
  function automatic int exp_out();
    if (rst === 1'b1)  return 0;
    if (load === 1'b1) return int'(in);
    return model_cnt;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Checks out/co against literal values. It also pins the model to the same literal.
  task automatic check_out(input string name, input int exp_val);
    check({name, "_out"}, 32'(out), 32'(exp_val));
    check({name, "_co"}, 32'(co), (exp_val == ALL1) ? 32'd1 : 32'd0);
    check({name, "_model"}, 32'(exp_out()), 32'(exp_val));
  endtask

  // Moves to one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares the DUT with the model during the random phase. The checks run at
  // +1, +4 and +8 after each edge; the driver changes inputs at +2 and +6.
  task automatic cmp(input string tag);
    check({tag, "_out"}, 32'(out), 32'(exp_out()));
    check({tag, "_co"}, 32'(co), (exp_out() == ALL1) ? 32'd1 : 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rand_on) begin
        #1 cmp("rand_post_edge");
        #3 cmp("rand_early");
        #4 cmp("rand_mid");
      end
    end
  end

  initial begin
    // Reset: rst=1, load=0, in=2 for 2 clocks.
    rst = 1'b1; load = 1'b0; in = 4'h2;
    #1 check_out("reset_t0", 0);
    tick(); check_out("reset_e1", 0);
    tick(); check_out("reset_e2", 0);
    rst = 1'b0;
    #1 check_out("reset_released_pre_edge", 0);
    tick(); check_out("count_1", 1);
    tick(); check_out("count_2", 2);
    tick(); check_out("count_3", 3);

    // Transparent load: in changes first (no effect), then load rises mid-cycle.
    in = 4'hA;
    #1 check_out("in_ignored", 3);
    #3 load = 1'b1;
    #1 check_out("transparent_A", 10);
    tick(); check_out("load_held_A", 10);
    load = 1'b0;
    #1 check_out("load_release_A", 10);
    tick(); check_out("after_load_B", 11);
    tick(); check_out("after_load_C", 12);

    // Wrap and carry.
    in = 4'hD; load = 1'b1;
    tick();
    load = 1'b0;
    #1 check_out("wrap_D", 13);
    tick(); check_out("wrap_E", 14);
    tick(); check_out("wrap_F", 15);
    tick(); check_out("wrap_0", 0);
    tick(); check_out("wrap_1", 1);

    // Live tracking during load: C then F between edges, and F stored at the edge.
    load = 1'b1; in = 4'hC;
    #1 check_out("live_C", 12);
    #2 in = 4'hF;
    #1 check_out("live_F", 15);
    tick(); check_out("live_F_edge", 15);
    in = 4'hC;
    #1 check_out("live_C_after_edge", 12);
    load = 1'b0;
    #1 check_out("stored_F_on_release", 15);
    tick(); check_out("stored_F_incr", 0);

    // Reset priority: rst and load together with in=7.
    rst = 1'b1; load = 1'b1; in = 4'h7;
    #1 check_out("rst_over_load", 0);
    tick(); check_out("rst_over_load_edge", 0);
    rst = 1'b0;
    #1 check_out("rst_drop_load_7", 7);
    load = 1'b0;
    #1 check_out("rst_cnt_zero", 0);
    tick(); check_out("rst_then_count", 1);

    // Short load pulse with no edge inside it, while cnt=5.
    in = 4'h5; load = 1'b1;
    tick();
    load = 1'b0;
    #1 check_out("pulse_cnt5", 5);
    in = 4'h9; load = 1'b1;
    #1 check_out("pulse_shows_in", 9);
    #2 load = 1'b0;
    #1 check_out("pulse_reverts", 5);
    tick(); check_out("pulse_then_6", 6);

    // Random phase. Inputs are driven at +2 and optionally again at +6 after each edge.
    @(posedge clk);
    rand_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      #2;
      rst  = ($urandom_range(0, 15) == 0);
      load = ($urandom_range(0, 2) == 0);
      in   = WIDTH'($urandom);
      #4;
      if ($urandom_range(0, 3) == 0) in = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) load = ~load;
      if ($urandom_range(0, 31) == 0) rst = ~rst;
      @(posedge clk);
    end
    rand_on = 1'b0;
    #10;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
